control_cursa: RTL and testbench
================================

# control_cursa

Race sequencer for the line-follower car. It watches the five line sensors, debounces the finish-line pattern, counts laps, and decides when the motors may run or must brake, based on the selected circuit mode. It sits between the circuit selector and the combinational movement logic. `run_en`/`frana` gate the motor direction outputs, and `count_ture`/`tact_count` feed the lap display.

## Interface
- `DEBOUNCE_CYC`, default 1000: consecutive synchronized cycles the finish pattern must hold before a lap is counted.
- `BLANK_CYC`, default 50_000_000: minimum cycles after a lap during which the finish pattern is ignored.
- `LOST_CYC`, default 25_000_000: line-loss timeout in cycles; only used with `CONTROL_CURSA_LOST_LINE_EN`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start button level, asynchronous; a rising edge is detected after synchronization.
- `circuit` in 2: mode. 00 = reset/idle, 01 = circuit 1, 10 = curve test, 11 = endurance.
- `senzor_1` … `senzor_5` in 1 each: line sensors, asynchronous; 1 = black detected.
- `run_en` out 1: motors allowed to follow the line.
- `frana` out 1: brake override; forces both driver directions to 00.
- `count_ture` out 4: laps completed.
- `tact_count` out 1: one-cycle pulse per counted lap.
- `done` out 1: target lap count reached.
- `eroare` out 1: line lost (watchdog).
- `stare` out 3: current state code, for debug LEDs.

## Operation
- All asynchronous inputs pass through 2-flop synchronizers. `fin` = synchronized {s1,s2,s4,s5} == 4'b1111.
- States: IDLE, RUN, LAP, BLANK, STOP.
- IDLE: `run_en`=0, `frana`=1. A rising edge of `start` with `circuit`≠00 latches `circuit` into `circ_q`, clears the debounce counter, and moves to RUN.
- RUN: `run_en`=1, `frana`=0.
  - The debounce counter increments while `fin`=1 and clears when `fin`=0.
  - When the counter reaches DEBOUNCE_CYC-1 with `fin`=1, the next state is LAP.
- LAP lasts exactly one cycle.
  - `count_ture` increments on entry and saturates at 15.
  - `tact_count`=1 while in LAP.
  - Next state is STOP if the target is reached, otherwise BLANK.
  - Targets: `circ_q`=01 → 1 lap, 10 → 10 laps, 11 → none (runs until power is lost or `circuit`=00).
- BLANK: `run_en`=1. A counter runs BLANK_CYC cycles. The state returns to RUN once the counter has expired and `fin`=0; if `fin` is still 1, it stays in BLANK.
- STOP: `run_en`=0, `frana`=1, `done`=1 (or `eroare`=1 for the watchdog stop). The state is held until `circuit`=00.
- `circuit`=00 in any state: next state is IDLE, and `count_ture`, `done`, `eroare` and all counters clear. This has priority over every other transition.
- Changes of `circuit` between nonzero values while not in IDLE are ignored; `circ_q` is used.
- A `start` edge outside IDLE is ignored.
- A finish pattern in IDLE or STOP is ignored.

## Timing
- Reset values: state IDLE, `run_en`=0, `frana`=1, `count_ture`=0, `tact_count`=0, `done`=0, `eroare`=0, `stare`=IDLE code, all counters 0, synchronizers 0.
- All outputs are registered Moore decodes of the state and count registers.
- Latency from sensor pins to LAP is 2 (sync) + DEBOUNCE_CYC cycles of a stable pattern.
- `count_ture` shows the new value in the same cycle `tact_count`=1.
- From `start` pin rising to RUN is 3 cycles (2 sync + edge detect).
- Reset asserted mid-run forces IDLE outputs immediately (asynchronously) and loses the lap count.
- Simultaneous `start` edge and `circuit`=00: IDLE wins.

## Configuration
- `CONTROL_CURSA_LOST_LINE_EN` defined:
  - In RUN and BLANK, a lost counter increments while all five synchronized sensors are 0, and clears on any 1.
  - At LOST_CYC the state goes to STOP with `eroare`=1 and `done`=0.
- Not defined: no counter is built, `eroare` is tied to 0, and `LOST_CYC` is unused.

## Structure
- Package `control_cursa_pkg` holds the state enum/codes, the circuit codes (CIRC_RESET, CIRC_1, CIRC_CURBE, CIRC_ANDURANTA) and the target-lap constants (1, 10).
- One sub-module, `sincronizator_intrare`: a 2-flop synchronizer, parameterized by width, used for the 5 sensors plus `start`.
- The FSM, counters and edge detect live in `control_cursa`.

## Test plan
All scenarios use DEBOUNCE_CYC=4, BLANK_CYC=8, LOST_CYC=16.
- Reset with `circuit`=01, no `start` → `run_en`=0, `frana`=1, `count_ture`=0 for 20 cycles.
- `circuit`=01, `start` pulse, then `fin` held 6 cycles → `tact_count` pulses once, `count_ture`=1, STOP with `done`=1, `frana`=1.
- `circuit`=10, 10 separated finish crossings of 5 cycles each → `count_ture`=10, `done`=1. An 11th crossing leaves the count at 10.
- `circuit`=11, `fin` held 30 cycles continuously → exactly one lap counted (state stays in BLANK until `fin`=0). A 3-cycle glitch → no count.
- Mid-run `circuit`=00 → IDLE next cycle, `count_ture`=0. `circuit` changed 10→01 mid-run → target remains 10.
- With `CONTROL_CURSA_LOST_LINE_EN`: all sensors 0 for 16 cycles in RUN → STOP, `eroare`=1. Without the macro → stays in RUN, `eroare`=0.

Source files
------------

// File: rtl/control_cursa_pkg.sv
// control_cursa_pkg
// Shared definitions for the race sequencer: FSM state codes (also shown on
// the debug LEDs through `stare`), circuit selector codes, the lap targets of
// each circuit and a helper that decides whether the target has been reached.
package control_cursa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_LAP   = 3'd2,
        ST_BLANK = 3'd3,
        ST_STOP  = 3'd4
    } stare_t;

    localparam logic [1:0] CIRC_RESET     = 2'b00;
    localparam logic [1:0] CIRC_1         = 2'b01;
    localparam logic [1:0] CIRC_CURBE     = 2'b10;
    localparam logic [1:0] CIRC_ANDURANTA = 2'b11;

    localparam logic [3:0] TURE_CIRC_1 = 4'd1;
    localparam logic [3:0] TURE_CURBE  = 4'd10;
    localparam logic [3:0] TURE_MAX    = 4'd15;

    // Endurance mode has no target: the car keeps lapping until the selector
    // goes back to CIRC_RESET.
    function automatic logic target_atins(input logic [1:0] circ, input logic [3:0] ture);
        logic atins;
        atins = 1'b0;
        case (circ)
            CIRC_1:     atins = (ture >= TURE_CIRC_1);
            CIRC_CURBE: atins = (ture >= TURE_CURBE);
            default:    atins = 1'b0;
        endcase
        return atins;
    endfunction

endpackage

// File: rtl/control_cursa_sincronizator.sv
// sincronizator_intrare
// Two-flop synchronizer for asynchronous level inputs (line sensors, start
// button). Each bit is synchronized independently.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset, clears both stages
//   d_in  - asynchronous inputs
//   q_out - inputs synchronized to clk, two cycles of latency
module sincronizator_intrare #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; only the second stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign q_out = sync_q;

endmodule

// File: rtl/control_cursa.sv
// control_cursa
// Race sequencer for the line-follower car: synchronizes the five line
// sensors and the start button, debounces the finish-line pattern, counts
// laps, and decides when the motors may run or must brake.
// Optional feature: define CONTROL_CURSA_LOST_LINE_EN to build the line-loss
// watchdog (stops the car with `eroare` after LOST_CYC all-white cycles).
// Ports:
//   clk, rst               - clock, asynchronous active-high reset
//   start                  - start button level (asynchronous)
//   circuit[1:0]           - mode: 00 idle, 01 circuit 1, 10 curves, 11 endurance
//   senzor_1 .. senzor_5   - line sensors, 1 = black (asynchronous)
//   run_en / frana         - motors may follow the line / brake override
//   count_ture[3:0]        - laps completed (saturates at 15)
//   tact_count             - one-cycle pulse per counted lap
//   done / eroare          - target reached / line lost
//   stare[2:0]             - current state code for debug LEDs
module control_cursa #(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int BLANK_CYC    = 50_000_000,
    parameter int LOST_CYC     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] circuit,
    input  logic       senzor_1,
    input  logic       senzor_2,
    input  logic       senzor_3,
    input  logic       senzor_4,
    input  logic       senzor_5,
    output logic       run_en,
    output logic       frana,
    output logic [3:0] count_ture,
    output logic       tact_count,
    output logic       done,
    output logic       eroare,
    output logic [2:0] stare
);

    import control_cursa_pkg::*;

    localparam int DEB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int BLANK_W = $clog2(BLANK_CYC + 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYC - 1);

    logic [5:0] sync_bus;
    logic [4:0] sens_s;
    logic       start_s;
    logic       fin;
    logic       start_rise;
    logic       blank_gata;
    logic       lost_hit;

    stare_t             state_q, state_d;
    logic [1:0]         circ_q, circ_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [3:0]         count_q, count_d;
    logic               start_prev_q, start_prev_d;

    sincronizator_intrare #(.WIDTH(6)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  ({start, senzor_5, senzor_4, senzor_3, senzor_2, senzor_1}),
        .q_out (sync_bus)
    );

    assign sens_s     = sync_bus[4:0];
    assign start_s    = sync_bus[5];
    // The middle sensor is excluded: the finish line is a full-width stripe
    // while the track line itself only covers the centre.
    assign fin        = sens_s[0] & sens_s[1] & sens_s[3] & sens_s[4];
    assign start_rise = start_s & ~start_prev_q;
    assign blank_gata = (blank_cnt_q == BLANK_LAST);

`ifdef CONTROL_CURSA_LOST_LINE_EN
    localparam int LOST_W = $clog2(LOST_CYC + 1);
    localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_CYC - 1);

    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic              err_q, err_d;
    logic              linie_pierduta;
    logic              in_cursa;

    assign linie_pierduta = (sens_s == 5'b00000);
    assign in_cursa       = (state_q == ST_RUN) || (state_q == ST_BLANK);
    assign lost_hit       = in_cursa && linie_pierduta && (lost_cnt_q == LOST_LAST);

    // Watchdog: counts consecutive all-white cycles while racing; err flags
    // that the next STOP is an error stop rather than a finished race.
    always_comb begin
        lost_cnt_d = '0;
        err_d      = err_q;
        if (circuit == CIRC_RESET) begin
            err_d = 1'b0;
        end else begin
            if (in_cursa && linie_pierduta) begin
                lost_cnt_d = lost_cnt_q + 1'b1;
            end
            if (lost_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            lost_cnt_q <= lost_cnt_d;
            err_q      <= err_d;
        end
    end
`else
    localparam int unused_lost_cyc = LOST_CYC;
    logic unused_senzor_3;
    logic err_q;

    assign unused_senzor_3 = sens_s[2];
    assign lost_hit        = 1'b0;
    assign err_q           = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            circ_q       <= CIRC_RESET;
            deb_cnt_q    <= '0;
            blank_cnt_q  <= '0;
            count_q      <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            circ_q       <= circ_d;
            deb_cnt_q    <= deb_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            count_q      <= count_d;
            start_prev_q <= start_prev_d;
        end
    end

    // Next state. Selecting CIRC_RESET returns to IDLE from anywhere and
    // outranks a simultaneous start edge.
    always_comb begin
        state_d = state_q;
        if (circuit == CIRC_RESET) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start_rise) state_d = ST_RUN;
                ST_RUN: begin
                    if (lost_hit)                          state_d = ST_STOP;
                    else if (fin && deb_cnt_q == DEB_LAST) state_d = ST_LAP;
                end
                ST_LAP:   state_d = target_atins(circ_q, count_q) ? ST_STOP : ST_BLANK;
                ST_BLANK: begin
                    if (lost_hit)                state_d = ST_STOP;
                    else if (blank_gata && !fin) state_d = ST_RUN;
                end
                ST_STOP:  state_d = ST_STOP;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Counters and latched mode. Debounce and blanking counters only live in
    // their own state, so they are always zero on entry.
    always_comb begin
        circ_d       = circ_q;
        deb_cnt_d    = '0;
        blank_cnt_d  = '0;
        count_d      = count_q;
        start_prev_d = start_s;
        if (circuit == CIRC_RESET) begin
            count_d = '0;
        end else begin
            if (state_q == ST_IDLE && start_rise) begin
                circ_d = circuit;
            end
            if (state_q == ST_RUN && fin) begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
            if (state_q == ST_RUN && state_d == ST_LAP && count_q != TURE_MAX) begin
                count_d = count_q + 4'd1;
            end
            if (state_q == ST_BLANK) begin
                blank_cnt_d = blank_gata ? blank_cnt_q : blank_cnt_q + 1'b1;
            end
        end
    end

    // Moore output decode of the registered state.
    always_comb begin
        run_en     = 1'b0;
        frana      = 1'b1;
        tact_count = 1'b0;
        done       = 1'b0;
        eroare     = 1'b0;
        case (state_q)
            ST_RUN, ST_BLANK: begin
                run_en = 1'b1;
                frana  = 1'b0;
            end
            ST_LAP: begin
                run_en     = 1'b1;
                frana      = 1'b0;
                tact_count = 1'b1;
            end
            ST_STOP: begin
                done   = ~err_q;
                eroare = err_q;
            end
            default: ;
        endcase
    end

    assign count_ture = count_q;
    assign stare      = state_q;

endmodule

// File: tb/tb_control_cursa.sv
// tb_control_cursa
// Self-checking bench for control_cursa with small timing parameters. Every
// cycle the DUT outputs are compared against a race-level reference model
// that tracks pin history, run lengths of the finish pattern, time spent in
// the blanking window and the lap tally.
module tb_control_cursa;

    localparam int D = 4;
    localparam int B = 8;
    localparam int L = 16;
`ifdef CONTROL_CURSA_LOST_LINE_EN
    localparam bit LOST_EN = 1'b1;
`else
    localparam bit LOST_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] circuit;
    logic       senzor_1, senzor_2, senzor_3, senzor_4, senzor_5;
    logic       run_en, frana, tact_count, done, eroare;
    logic [3:0] count_ture;
    logic [2:0] stare;

    int vectors     = 0;
    int miscompares = 0;

    control_cursa #(.DEBOUNCE_CYC(D), .BLANK_CYC(B), .LOST_CYC(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .circuit    (circuit),
        .senzor_1   (senzor_1),
        .senzor_2   (senzor_2),
        .senzor_3   (senzor_3),
        .senzor_4   (senzor_4),
        .senzor_5   (senzor_5),
        .run_en     (run_en),
        .frana      (frana),
        .count_ture (count_ture),
        .tact_count (tact_count),
        .done       (done),
        .eroare     (eroare),
        .stare      (stare)
    );

    always #5 clk = ~clk;

    // Reference model: the race phase plus plain integer tallies.
    typedef enum int {M_IDLE, M_RACE, M_LAP, M_BLANK, M_STOP} phase_t;
    phase_t     phase;
    int         laps, target, finRun, blankAge, zeroRun;
    bit         errStop;
    logic [5:0] pinsDly1, pinsDly2;
    logic       prevStart;

    task automatic modelReset();
        phase     = M_IDLE;
        laps      = 0;
        target    = 0;
        finRun    = 0;
        blankAge  = 0;
        zeroRun   = 0;
        errStop   = 1'b0;
        pinsDly1  = '0;
        pinsDly2  = '0;
        prevStart = 1'b0;
    endtask

    // Advance the model by one clock edge given the pins present before it.
    task automatic modelStep(input logic [4:0] sens, input logic st, input logic [1:0] circ);
        logic [4:0] seen;
        bit         isFin, allWhite, rise;
        seen     = pinsDly2[4:0];
        isFin    = seen[0] && seen[1] && seen[3] && seen[4];
        allWhite = (seen == 5'b00000);
        rise     = pinsDly2[5] && !prevStart;
        if (circ == 2'b00) begin
            phase    = M_IDLE;
            laps     = 0;
            finRun   = 0;
            blankAge = 0;
            zeroRun  = 0;
            errStop  = 1'b0;
        end else begin
            if (phase == M_RACE || phase == M_BLANK)
                zeroRun = (LOST_EN && allWhite) ? zeroRun + 1 : 0;
            else
                zeroRun = 0;
            case (phase)
                M_IDLE: if (rise) begin
                    target = (circ == 2'b01) ? 1 : (circ == 2'b10) ? 10 : 0;
                    finRun = 0;
                    phase  = M_RACE;
                end
                M_RACE: if (zeroRun == L) begin
                    phase   = M_STOP;
                    errStop = 1'b1;
                end else begin
                    finRun = isFin ? finRun + 1 : 0;
                    if (finRun == D) begin
                        laps   = (laps < 15) ? laps + 1 : 15;
                        finRun = 0;
                        phase  = M_LAP;
                    end
                end
                M_LAP: if (target != 0 && laps >= target) phase = M_STOP;
                       else begin
                           blankAge = 0;
                           phase    = M_BLANK;
                       end
                M_BLANK: if (zeroRun == L) begin
                    phase   = M_STOP;
                    errStop = 1'b1;
                end else begin
                    blankAge++;
                    if (blankAge >= B && !isFin) begin
                        finRun = 0;
                        phase  = M_RACE;
                    end
                end
                default: ;
            endcase
        end
        prevStart = pinsDly2[5];
        pinsDly2  = pinsDly1;
        pinsDly1  = {st, sens};
    endtask

    // Compare all outputs with the model; motor gating in the lap cycle is
    // left unchecked.
    task automatic checkOutput(input string tag);
        logic [8:0] obs, exp, mask;
        obs  = {run_en, frana, count_ture, tact_count, done, eroare};
        exp  = {phase inside {M_RACE, M_LAP, M_BLANK}, phase inside {M_IDLE, M_STOP},
                4'(laps), phase == M_LAP, phase == M_STOP && !errStop, phase == M_STOP && errStop};
        mask = (phase == M_LAP) ? 9'b001111111 : 9'b111111111;
        vectors++;
        assert ((obs & mask) === (exp & mask)) else begin
            miscompares++;
            $error("[TB] FAIL %s: outputs {run_en,frana,count,tact,done,eroare} observed %b expected %b",
                   tag, obs, exp);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] sens, input logic st, input logic [1:0] circ,
                                 input string tag);
        {senzor_5, senzor_4, senzor_3, senzor_2, senzor_1} = sens;
        start   = st;
        circuit = circ;
        modelStep(sens, st, circ);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    function automatic logic [4:0] lineSens();
        logic [4:0] v;
        v    = 5'($urandom);
        v[2] = 1'b1;
        if (v[0] && v[1] && v[3] && v[4]) v[0] = 1'b0;
        return v;
    endfunction

    function automatic logic [4:0] finSens();
        logic [4:0] v;
        v    = 5'b11011;
        v[2] = 1'($urandom);
        return v;
    endfunction

    task automatic raceStart(input logic [1:0] circ);
        applyStimulus(lineSens(), 1'b1, circ, "start");
        repeat (4) applyStimulus(lineSens(), 1'b0, circ, "to_run");
    endtask

    task automatic crossing(input logic [1:0] circ, input int finCyc, input int gapCyc);
        repeat (finCyc) applyStimulus(finSens(), 1'b0, circ, "finish");
        repeat (gapCyc) applyStimulus(lineSens(), 1'b0, circ, "gap");
    endtask

    initial begin
        logic [4:0] burstSens;
        logic [1:0] curCirc;
        int         burstLeft;

        rst = 1'b1;
        start = 1'b0;
        circuit = 2'b01;
        {senzor_5, senzor_4, senzor_3, senzor_2, senzor_1} = 5'b00000;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_state");
        rst = 1'b0;

        // Selector on circuit 1 but no start: car must stay braked.
        repeat (20) applyStimulus(lineSens(), 1'b0, 2'b01, "idle_no_start");

        // Circuit 1: one crossing finishes the race.
        raceStart(2'b01);
        crossing(2'b01, 6, 6);
        checkValue("c1_count", count_ture, 1);
        checkValue("c1_done", done, 1);
        checkValue("c1_frana", frana, 1);
        applyStimulus(lineSens(), 1'b0, 2'b00, "c1_clear");
        checkValue("c1_cleared", count_ture, 0);

        // Curve test: ten laps, an eleventh crossing is ignored.
        raceStart(2'b10);
        for (int i = 0; i < 10; i++) crossing(2'b10, 5, $urandom_range(11, 14));
        checkValue("curbe_count", count_ture, 10);
        checkValue("curbe_done", done, 1);
        crossing(2'b10, 5, 12);
        checkValue("curbe_11th", count_ture, 10);
        applyStimulus(lineSens(), 1'b0, 2'b00, "curbe_clear");

        // Endurance: a long finish stripe is one lap; a short glitch is none.
        raceStart(2'b11);
        crossing(2'b11, 30, 12);
        checkValue("andur_long", count_ture, 1);
        crossing(2'b11, 3, 8);
        checkValue("andur_glitch", count_ture, 1);
        checkValue("andur_running", run_en, 1);
        applyStimulus(lineSens(), 1'b0, 2'b00, "midrun_zero");
        checkValue("midrun_zero_run", run_en, 0);
        checkValue("midrun_zero_count", count_ture, 0);

        // Selector moved from curves to circuit 1 mid-race: target stays 10.
        raceStart(2'b10);
        crossing(2'b01, 5, 12);
        crossing(2'b01, 5, 12);
        checkValue("retarget_count", count_ture, 2);
        checkValue("retarget_done", done, 0);

        // Line lost for longer than the watchdog limit.
        repeat (L + 4) applyStimulus(5'b00000, 1'b0, 2'b01, "lost_line");
        checkValue("lost_eroare", eroare, LOST_EN ? 1 : 0);
        checkValue("lost_run_en", run_en, LOST_EN ? 0 : 1);
        checkValue("lost_done", done, 0);
        applyStimulus(lineSens(), 1'b0, 2'b00, "lost_clear");

        // Asynchronous reset in the middle of a race.
        raceStart(2'b11);
        crossing(2'b11, 5, 3);
        rst = 1'b1;
        modelReset();
        #2;
        checkOutput("async_reset");
        checkValue("async_reset_count", count_ture, 0);
        rst = 1'b0;
        repeat (5) applyStimulus(lineSens(), 1'b0, 2'b11, "after_reset");

        // Random traffic: sensor bursts, occasional start presses and mode changes.
        curCirc   = 2'b11;
        burstLeft = 0;
        burstSens = lineSens();
        for (int i = 0; i < 600; i++) begin
            if (burstLeft == 0) begin
                burstLeft = $urandom_range(1, 8);
                case ($urandom_range(0, 5))
                    0, 1:    burstSens = finSens();
                    2:       burstSens = 5'b00000;
                    default: burstSens = lineSens();
                endcase
            end
            burstLeft--;
            if ($urandom_range(0, 59) == 0) curCirc = 2'($urandom);
            applyStimulus(burstSens, $urandom_range(0, 14) == 0, curCirc, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
